cpipe1_fetch_stage: RTL and testbench
=====================================

# cpipe1_fetch_stage

Holds the CPIPE1 opcode register and a small prefetch queue in front of it. Its registered output `CPIPE1s[7:0]` drives the CPIPE1 control-decode PLA. The block takes back that PLA's `CPIPE1load1` and `CPIPE1flush` decisions to advance, stall or squash the pipe. It also sequences reset: the asynchronous active-low board reset becomes the stretched, synchronous active-high `RESET` that the decode PLA consumes.

## Interface
- `DEPTH`, default 2: prefetch queue entries (2 or 4).
- `NOP_OPCODE`, default 8'hA0: bubble encoding. The PLA decodes it with `CPIPE1load1`=1 and `CPIPE1flush`=0.
- `RESET_HOLD`, default 4: cycles `RESET` stays high after `RESETn` deasserts (1..15).

Ports:
- `CLK`  in  1  sole clock, rising edge.
- `RESETn`  in  1  asynchronous, active-low reset.
- `WAIT`  in  1  memory wait; freezes pipe advance.
- `IFvalid`  in  1  fetched opcode present on `DATABUS`.
- `DATABUS`  in  8  fetched opcode byte.
- `IFready`  out  1  queue can accept a push this cycle.
- `CPIPE1load1`  in  1  from decode PLA: advance CPIPE1.
- `CPIPE1flush`  in  1  from decode PLA: squash wrong-path opcodes.
- `CPIPE1s`  out  8  registered opcode to PLA. Bit 6 is carried but unused downstream.
- `CPIPE1valid`  out  1  `CPIPE1s` holds a real fetched opcode, not a bubble.
- `RESET`  out  1  synchronous active-high reset to the PLA.

## Operation
- **Reset sequencer.**
  - `RESETn` low: immediately sets `RESET`=1 and `hold_cnt`=0.
  - After release, `hold_cnt` increments each cycle. `RESET` drops on the edge where `hold_cnt` reaches `RESET_HOLD`, and the counter then saturates.
- **While `RESET`=1:**
  - `CPIPE1s`=`NOP_OPCODE`, `CPIPE1valid`=0.
  - Queue is empty; `IFready`=0.
- **Queue.** FIFO of `DEPTH` bytes with an occupancy count `cnt` of width log2(DEPTH)+1.
  - `IFready` = ~`RESET` & (`cnt` < `DEPTH`).
  - A push occurs when `IFvalid` & `IFready`. Pushes are allowed during `WAIT`.
- **Advance.** Occurs when ~`WAIT` & ~`RESET` & `CPIPE1load1` & ~`CPIPE1flush`.
  - If `cnt` > 0: pop the head into `CPIPE1s` and set `CPIPE1valid`=1.
  - If `cnt` = 0: load `NOP_OPCODE` with `CPIPE1valid`=0 (bubble). There is no same-cycle bypass from `DATABUS`.
- **Flush.** Occurs when ~`WAIT` & ~`RESET` & `CPIPE1flush`.
  - Queue is cleared. A same-cycle push is discarded.
  - `CPIPE1s`=`NOP_OPCODE`, `CPIPE1valid`=0.
  - Flush beats advance.
- **Flush during `WAIT`.** No effect. The register holds, so the PLA re-asserts the flush after `WAIT` drops.
- **Hold.** `WAIT`, or `CPIPE1load1`=0: `CPIPE1s` and `CPIPE1valid` are unchanged.
- **Simultaneous push and pop.** `cnt` is unchanged. The pushed byte enters behind the remaining entries, and the popped head is the oldest byte.
- **Pointers.** Read and write pointers wrap modulo `DEPTH`. Overflow is impossible because of `IFready`; underflow is impossible by the pop guard.

## Timing
- All state changes on the rising `CLK` edge, except `RESETn` assertion, which acts asynchronously.
- Reset values:
  - `CPIPE1s`=`NOP_OPCODE`, `CPIPE1valid`=0, `RESET`=1, `IFready`=0.
  - `cnt`=0, both pointers 0.
- Release: first push is possible on the cycle after `RESET` falls, i.e. `RESET_HOLD`+1 cycles after the `RESETn` rise.
- Latency, empty pipe: push at edge N; earliest appearance on `CPIPE1s` at edge N+1, given an advance condition in cycle N+1.
- `IFready` is combinational from `cnt` and `RESET`. It never depends on `IFvalid`.
- `RESETn` asserted mid-queue: all contents are lost and outputs revert to reset values asynchronously.

## Test plan
- **Reset stretch.** Hold `RESETn`=0 for 3 cycles, then release with `RESET_HOLD`=4.
  - `RESET`=1 for exactly 4 edges after release.
  - `IFready` rises with `RESET` falling.
  - `CPIPE1s`=8'hA0 and `CPIPE1valid`=0 throughout.
- **Streaming.** Push 8'h81, 8'h92, 8'h83 on consecutive cycles with `CPIPE1load1`=1 and `WAIT`=0.
  - `CPIPE1s` shows 81, 92, 83 on successive edges, each one cycle after its push.
  - `CPIPE1valid`=1 for those cycles.
- **Stall fill.** Hold `WAIT`=1 and push 3 bytes with `DEPTH`=2.
  - `IFready`=0 after the 2nd push; the 3rd byte is held by the source.
  - Drop `WAIT`: bytes drain in order with no loss.
- **Flush.** Queue holds {C1, C2}; assert `CPIPE1flush` while pushing C3.
  - Next edge: `CPIPE1s`=A0, `CPIPE1valid`=0, `cnt`=0.
  - C1, C2 and C3 never appear.
- **Flush deferred.** Assert `CPIPE1flush` with `WAIT`=1 for 2 cycles: no change. Squash occurs on the first edge with `WAIT`=0.
- **Underflow and mid-operation reset.**
  - Advance with the queue empty: bubble A0/valid=0, `cnt` stays 0.
  - Drop `RESETn` with 2 entries queued: immediate reset values, and the queue is empty after release.

Source files
------------

// File: rtl/cpipe1_fetch_stage_if.sv
// Fetch/decode handshake bundle around the CPIPE1 fetch stage.
// The fetch stage uses the slave modport; the fetch source and decode PLA
// side (or a testbench standing in for them) use the master modport.
interface cpipe1_fetch_stage_if;
    logic       WAIT;
    logic       IFvalid;
    logic [7:0] DATABUS;
    logic       IFready;
    logic       CPIPE1load1;
    logic       CPIPE1flush;
    logic [7:0] CPIPE1s;
    logic       CPIPE1valid;
    logic       RESET;

    modport master (
        output WAIT, IFvalid, DATABUS, CPIPE1load1, CPIPE1flush,
        input  IFready, CPIPE1s, CPIPE1valid, RESET
    );

    modport slave (
        input  WAIT, IFvalid, DATABUS, CPIPE1load1, CPIPE1flush,
        output IFready, CPIPE1s, CPIPE1valid, RESET
    );
endinterface

// File: rtl/cpipe1_fetch_stage.sv
// CPIPE1 opcode register with a small prefetch FIFO in front of it, plus the
// reset stretcher that turns the async board reset into the PLA's sync RESET.
module cpipe1_fetch_stage #(
    parameter int         DEPTH      = 2,
    parameter logic [7:0] NOP_OPCODE = 8'hA0,
    parameter int         RESET_HOLD = 4
) (
    input logic                  CLK,
    input logic                  RESETn,
    cpipe1_fetch_stage_if.slave  bus
);
    localparam int         PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int         CNT_W = PTR_W + 1;
    localparam logic [3:0] HOLD  = 4'(RESET_HOLD);

    logic [3:0]       hold_cnt;
    logic             reset_q;
    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       opcode_q;
    logic             valid_q;

    logic active;
    logic do_flush;
    logic do_adv;
    logic do_push;
    logic do_pop;

    // Pointers wrap explicitly so a non-power-of-two depth would still be safe.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Pipe control decisions; flush wins over advance and squashes a same-cycle push.
    assign active   = ~bus.WAIT & ~reset_q;
    assign do_flush = active & bus.CPIPE1flush;
    assign do_adv   = active & bus.CPIPE1load1 & ~bus.CPIPE1flush;
    assign do_push  = bus.IFvalid & bus.IFready & ~do_flush;
    assign do_pop   = do_adv & (cnt != '0);

    assign bus.IFready     = ~reset_q & (cnt < CNT_W'(DEPTH));
    assign bus.CPIPE1s     = opcode_q;
    assign bus.CPIPE1valid = valid_q;
    assign bus.RESET       = reset_q;

    // Reset stretcher: count cycles since release, drop RESET when the count hits RESET_HOLD.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            hold_cnt <= '0;
            reset_q  <= 1'b1;
        end else if (hold_cnt != HOLD) begin
            hold_cnt <= hold_cnt + 4'd1;
            reset_q  <= (hold_cnt + 4'd1) != HOLD;
        end
    end

    // Queue storage: written on an accepted push only.
    // NOTE: the data array is not reset; occupancy/pointers alone define which entries are live.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= bus.DATABUS;
        end
    end

    // Queue bookkeeping: pointers and occupancy, cleared by reset phase or flush.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (reset_q || do_flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // CPIPE1 register: bubble on reset/flush, head or bubble on advance, else hold.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            opcode_q <= NOP_OPCODE;
            valid_q  <= 1'b0;
        end else if (reset_q || do_flush) begin
            opcode_q <= NOP_OPCODE;
            valid_q  <= 1'b0;
        end else if (do_adv) begin
            if (cnt != '0) begin
                opcode_q <= mem[rd_ptr];
                valid_q  <= 1'b1;
            end else begin
                opcode_q <= NOP_OPCODE;
                valid_q  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cpipe1_fetch_stage.sv
// Self-checking bench for cpipe1_fetch_stage: directed scenarios plus a random
// run, all compared against a queue-based reference model of the fetch stage.
module tb_cpipe1_fetch_stage;
    localparam int         DEPTH = 2;
    localparam logic [7:0] NOP   = 8'hA0;
    localparam int         HOLD  = 4;

    logic CLK    = 1'b0;
    logic RESETn = 1'b0;

    cpipe1_fetch_stage_if bus();

    cpipe1_fetch_stage #(
        .DEPTH      (DEPTH),
        .NOP_OPCODE (NOP),
        .RESET_HOLD (HOLD)
    ) dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .bus    (bus)
    );

    always #5 CLK = ~CLK;

    // Reference model: byte queue, opcode register, cycles since RESETn release.
    logic [7:0] q[$];
    logic [7:0] m_s   = NOP;
    bit         m_v   = 1'b0;
    int         since = 0;

    int n_pass  = 0;
    int n_total = 0;
    bit accepted;

    function automatic bit m_reset();
        return (RESETn !== 1'b1) || (since < HOLD);
    endfunction

    // One clock cycle: drive at negedge, check IFready, model the edge, check outputs.
    task automatic cycle(input bit w, input bit iv, input logic [7:0] d,
                         input bit ld, input bit fl);
        bit exp_ready;
        bit fl_eff;
        bit adv;
        bit push;
        bus.WAIT        = w;
        bus.IFvalid     = iv;
        bus.DATABUS     = d;
        bus.CPIPE1load1 = ld;
        bus.CPIPE1flush = fl;
        #1;
        exp_ready = !m_reset() && (q.size() < DEPTH);
        n_total++;
        if (bus.IFready !== exp_ready)
            $display("FAIL ifready got %b want %b at %0t", bus.IFready, exp_ready, $time);
        else
            n_pass++;
        @(posedge CLK);
        accepted = iv && exp_ready;
        if (RESETn !== 1'b1) begin
            q.delete();
            m_s   = NOP;
            m_v   = 1'b0;
            since = 0;
        end else if (m_reset()) begin
            q.delete();
            m_s = NOP;
            m_v = 1'b0;
            since++;
        end else begin
            fl_eff = !w && fl;
            adv    = !w && ld && !fl;
            push   = accepted && !fl_eff;
            if (fl_eff) begin
                q.delete();
                m_s = NOP;
                m_v = 1'b0;
            end else if (adv) begin
                if (q.size() > 0) begin
                    m_s = q.pop_front();
                    m_v = 1'b1;
                end else begin
                    m_s = NOP;
                    m_v = 1'b0;
                end
            end
            if (push) q.push_back(d);
            if (since < 1000) since++;
        end
        #1;
        n_total++;
        if (bus.CPIPE1s !== m_s)
            $display("FAIL cpipe1s got %h want %h at %0t", bus.CPIPE1s, m_s, $time);
        else
            n_pass++;
        n_total++;
        if (bus.CPIPE1valid !== m_v)
            $display("FAIL cpipe1valid got %b want %b at %0t", bus.CPIPE1valid, m_v, $time);
        else
            n_pass++;
        n_total++;
        if (bus.RESET !== m_reset())
            $display("FAIL reset_out got %b want %b at %0t", bus.RESET, m_reset(), $time);
        else
            n_pass++;
        @(negedge CLK);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Assert RESETn mid-cycle, check async values, hold low, release at a negedge.
    task automatic do_reset(input int low_cycles);
        #2;
        RESETn = 1'b0;
        #1;
        n_total++;
        if (bus.CPIPE1s !== NOP || bus.CPIPE1valid !== 1'b0 ||
            bus.RESET !== 1'b1 || bus.IFready !== 1'b0)
            $display("FAIL async_reset got s=%h v=%b rst=%b rdy=%b want s=%h v=0 rst=1 rdy=0",
                     bus.CPIPE1s, bus.CPIPE1valid, bus.RESET, bus.IFready, NOP);
        else
            n_pass++;
        q.delete();
        m_s   = NOP;
        m_v   = 1'b0;
        since = 0;
        @(negedge CLK);
        repeat (low_cycles) idle();
        RESETn = 1'b1;
        since  = 0;
    endtask

    task automatic test_reset();
        int ones = 0;
        do_reset(3);
        for (int k = 0; k < 12 && bus.RESET === 1'b1; k++) begin
            ones++;
            n_total++;
            if (bus.CPIPE1s !== NOP || bus.CPIPE1valid !== 1'b0)
                $display("FAIL reset_outputs got s=%h v=%b want s=%h v=0",
                         bus.CPIPE1s, bus.CPIPE1valid, NOP);
            else
                n_pass++;
            idle();
        end
        n_total++;
        if (ones != HOLD)
            $display("FAIL reset_stretch got %0d cycles want %0d", ones, HOLD);
        else
            n_pass++;
        n_total++;
        if (bus.IFready !== 1'b1)
            $display("FAIL ready_after_reset got %b want 1", bus.IFready);
        else
            n_pass++;
    endtask

    task automatic test_streaming();
        logic [7:0] src [3];
        src[0] = 8'h81;
        src[1] = 8'h92;
        src[2] = 8'h83;
        cycle(1'b0, 1'b1, src[0], 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i < 2) cycle(1'b0, 1'b1, src[i+1], 1'b1, 1'b0);
            else       cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            n_total++;
            if (bus.CPIPE1s !== src[i] || bus.CPIPE1valid !== 1'b1)
                $display("FAIL stream_%0d got %h/%b want %h/1", i, bus.CPIPE1s, bus.CPIPE1valid, src[i]);
            else
                n_pass++;
        end
    endtask

    task automatic test_stall_fill();
        logic [7:0] src [3];
        logic [7:0] got[$];
        int idx = 0;
        src[0] = 8'h11;
        src[1] = 8'h22;
        src[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, src[idx], 1'b1, 1'b0);
            if (accepted) idx++;
            if (i == 1) begin
                n_total++;
                if (bus.IFready !== 1'b0)
                    $display("FAIL stall_full_ready got %b want 0", bus.IFready);
                else
                    n_pass++;
            end
        end
        n_total++;
        if (idx != 2)
            $display("FAIL stall_accepted got %0d want 2", idx);
        else
            n_pass++;
        for (int i = 0; i < 12 && got.size() < 3; i++) begin
            cycle(1'b0, idx < 3, (idx < 3) ? src[idx] : 8'h00, 1'b1, 1'b0);
            if (accepted) idx++;
            if (bus.CPIPE1valid === 1'b1) got.push_back(bus.CPIPE1s);
        end
        n_total++;
        if (got.size() != 3)
            $display("FAIL stall_drain_count got %0d want 3", got.size());
        else
            n_pass++;
        for (int i = 0; i < got.size() && i < 3; i++) begin
            n_total++;
            if (got[i] !== src[i])
                $display("FAIL stall_order_%0d got %h want %h", i, got[i], src[i]);
            else
                n_pass++;
        end
    endtask

    task automatic test_flush();
        cycle(1'b0, 1'b1, 8'hC1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 8'hC2, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 8'hC3, 1'b1, 1'b1);
        n_total++;
        if (bus.CPIPE1s !== NOP || bus.CPIPE1valid !== 1'b0)
            $display("FAIL flush got %h/%b want %h/0", bus.CPIPE1s, bus.CPIPE1valid, NOP);
        else
            n_pass++;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            n_total++;
            if (bus.CPIPE1valid !== 1'b0)
                $display("FAIL flush_leak got %h/%b want %h/0", bus.CPIPE1s, bus.CPIPE1valid, NOP);
            else
                n_pass++;
        end
    endtask

    task automatic test_flush_deferred();
        cycle(1'b0, 1'b1, 8'hD1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 8'hD2, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
            n_total++;
            if (bus.CPIPE1s !== 8'hD1 || bus.CPIPE1valid !== 1'b1)
                $display("FAIL flush_wait_hold got %h/%b want d1/1", bus.CPIPE1s, bus.CPIPE1valid);
            else
                n_pass++;
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        n_total++;
        if (bus.CPIPE1s !== NOP || bus.CPIPE1valid !== 1'b0)
            $display("FAIL flush_deferred got %h/%b want %h/0", bus.CPIPE1s, bus.CPIPE1valid, NOP);
        else
            n_pass++;
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        n_total++;
        if (bus.CPIPE1valid !== 1'b0)
            $display("FAIL flush_deferred_leak got %h/%b want %h/0", bus.CPIPE1s, bus.CPIPE1valid, NOP);
        else
            n_pass++;
    endtask

    task automatic test_underflow();
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            n_total++;
            if (bus.CPIPE1s !== NOP || bus.CPIPE1valid !== 1'b0 || bus.IFready !== 1'b1)
                $display("FAIL underflow got %h/%b rdy=%b want %h/0 rdy=1",
                         bus.CPIPE1s, bus.CPIPE1valid, bus.IFready, NOP);
            else
                n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        cycle(1'b0, 1'b1, 8'hE1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 8'hE2, 1'b0, 1'b0);
        n_total++;
        if (bus.IFready !== 1'b0)
            $display("FAIL mid_reset_full got %b want 0", bus.IFready);
        else
            n_pass++;
        do_reset(2);
        repeat (HOLD) idle();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            n_total++;
            if (bus.CPIPE1valid !== 1'b0)
                $display("FAIL mid_reset_leak got %h/%b want %h/0", bus.CPIPE1s, bus.CPIPE1valid, NOP);
            else
                n_pass++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                  8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0);
        end
    endtask

    initial begin
        bus.WAIT        = 1'b0;
        bus.IFvalid     = 1'b0;
        bus.DATABUS     = 8'h00;
        bus.CPIPE1load1 = 1'b0;
        bus.CPIPE1flush = 1'b0;
        @(negedge CLK);
        test_reset();
        test_streaming();
        test_stall_fill();
        test_flush();
        test_flush_deferred();
        test_underflow();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
